wb_stream_writer_ring: RTL and testbench
========================================

Name: wb_stream_writer_ring

Overview:
Memory-to-stream DMA engine and the next generation of the single-shot stream writer. A Wishbone B3 master reads a buffer from memory in incrementing bursts into an internal first-word-fall-through FIFO. It drains the FIFO onto a valid/ready stream that carries an end-of-buffer marker. The block adds one-shot and ring (continuous wrap) modes, error reporting, a transfer counter and an interrupt, all configured through a Wishbone slave register file.

Parameters:
WB_DW, 32, Wishbone and stream data width (multiple of 8).
WB_AW, 32, Wishbone address width.
FIFO_AW, 4, log2 of FIFO depth in words.
MAX_BURST_LEN, 2**FIFO_AW, maximum beats per burst (1..2**FIFO_AW).

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
wbm_adr_o  out  WB_AW  master byte address
wbm_dat_o  out  WB_DW  tied 0
wbm_sel_o  out  WB_DW/8  all ones
wbm_we_o  out  1  tied 0
wbm_cyc_o / wbm_stb_o  out  1  cycle / strobe
wbm_cti_o  out  3  010 incrementing, 111 last beat
wbm_bte_o  out  2  tied 00
wbm_dat_i  in  WB_DW  read data
wbm_ack_i / wbm_err_i / wbm_rty_i  in  1  terminations
stream_m_data_o  out  WB_DW  stream data
stream_m_valid_o  out  1  data valid
stream_m_ready_i  in  1  sink ready
stream_m_last_o  out  1  final word of buffer pass
wbs_adr_i  in  5  register byte address (word index = [4:2])
wbs_dat_i  in  WB_DW  write data
wbs_sel_i  in  WB_DW/8  ignored (full-word writes)
wbs_we_i / wbs_cyc_i / wbs_stb_i  in  1  slave controls
wbs_dat_o  out  WB_DW  read data
wbs_ack_o  out  1  ack
wbs_err_o / wbs_rty_o  out  1  tied 0
irq_o  out  1  interrupt, level

Behaviour:
- Registers:
  - 0 CTRL: [0] enable, [1] ring, [2] irq_en. A read of [0] returns busy.
  - 1 STATUS: [0] done, [1] bus_err; write 1 to clear each bit.
  - 2 START_ADR.
  - 3 BUF_SIZE, in words.
  - 4 BURST_SIZE, in words.
  - 5 TX_CNT, read-only.
  - Unmapped addresses read 0 and ignore writes.
- Slave: ack one cycle after cyc&stb, deasserted the following cycle (no back-to-back ack). Read data is registered.
- All outputs reset to 0. wbm_sel_o is constant all ones. FSM resets to IDLE and the FIFO to empty.
- Pass parameters (START_ADR, BUF_SIZE, BURST_SIZE clamped to 1..MAX_BURST_LEN, with 0 treated as 1) are latched when leaving IDLE and on every ring wrap. Writes during a pass apply from the next latch.
- FSM:
  - IDLE: enable=1 and BUF_SIZE≠0 → WAIT, with adr=start and rem=buf_size. enable=1 and BUF_SIZE=0 → set done, clear enable, remain IDLE.
  - WAIT: blen=min(burst,rem). When FIFO free count ≥ blen → BURST: assert cyc/stb, adr=current. If enable was cleared by software, go to IDLE instead (abort only at a burst boundary).
  - BURST:
    - Each ack pushes wbm_dat_i plus a last flag into the FIFO; the flag is set when rem==1. The beat also does adr += WB_DW/8, rem -= 1, TX_CNT += 1.
    - cti is 111 on the final beat of the burst (also for blen=1), otherwise 010.
    - After the final ack, cyc/stb drop the next cycle. Then: rem≠0 → WAIT; rem=0 → PASS_END.
  - PASS_END: set done. If ring=1 and enable=1, reload parameters, clear TX_CNT → WAIT. Otherwise clear enable → IDLE.
  - err during BURST: drop cyc/stb, set bus_err, clear enable → IDLE. Data already in the FIFO still drains.
  - rty during BURST: drop cyc for one cycle, return to WAIT. The burst restarts at the current address with the current rem; nothing is pushed.
- FIFO: depth 2**FIFO_AW, WB_DW+1 bits wide, FWFT.
  - Pushes never exceed free space; the free check guarantees this.
  - Simultaneous push and pop in the same cycle is legal, including when full or empty.
- Stream: valid = FIFO not empty. data and last come from the FIFO head. A pop happens when valid&ready. Data and last hold stable while valid&!ready.
- irq_o = irq_en & (done | bus_err), registered.
- busy = FSM not IDLE.
- Address arithmetic wraps modulo 2**WB_AW.

Test Plan:
- One-shot: START=0x1000, BUF=10, BURST=4, ready=1 → bursts of 4,4,2 at 0x1000/0x1010/0x1020, cti 010,010,010,111 etc. Stream sees 10 words in order, last on word 10. done=1, TX_CNT=10, enable reads 0.
- Backpressure: FIFO_AW=2, BUF=16, ready toggling 1-in-4 → no burst starts until free≥blen, FIFO never overflows, all 16 words arrive in order.
- Ring: BUF=3, BURST=2, ring=1 → addresses repeat 0x1000..0x1008, last on every 3rd word, done set each pass. Clear enable mid-pass → stops at the next burst boundary, no cyc afterwards.
- Error: err on beat 2 of the first burst → cyc drops next cycle, bus_err=1, irq_o=1 with irq_en=1, and 1 word drains. Write 1 to STATUS[1] → irq_o=0.
- Retry: rty on beat 3 (BURST=4, BUF=4) → burst restarts at 0x1008 with 2 beats, stream receives exactly 4 words.
- Corners: BUF=0 → done immediately, no wbm_cyc_o. BURST=0 → single-beat cti=111. Async rst asserted mid-burst → cyc/stb/valid go low without waiting for a clock edge.

Source files
------------

// File: rtl/wb_stream_writer_ring.sv
// Memory-to-stream DMA: Wishbone B3 burst reader feeding a FWFT FIFO drained onto a
// valid/ready stream, with one-shot/ring modes, error/retry handling and a slave register file.
module wb_stream_writer_ring #(
  parameter int WB_DW         = 32,
  parameter int WB_AW         = 32,
  parameter int FIFO_AW       = 4,
  parameter int MAX_BURST_LEN = 2**FIFO_AW
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [WB_AW-1:0]     wbm_adr_o,
  output logic [WB_DW-1:0]     wbm_dat_o,
  output logic [WB_DW/8-1:0]   wbm_sel_o,
  output logic                 wbm_we_o,
  output logic                 wbm_cyc_o,
  output logic                 wbm_stb_o,
  output logic [2:0]           wbm_cti_o,
  output logic [1:0]           wbm_bte_o,
  input  logic [WB_DW-1:0]     wbm_dat_i,
  input  logic                 wbm_ack_i,
  input  logic                 wbm_err_i,
  input  logic                 wbm_rty_i,
  output logic [WB_DW-1:0]     stream_m_data_o,
  output logic                 stream_m_valid_o,
  input  logic                 stream_m_ready_i,
  output logic                 stream_m_last_o,
  input  logic [4:0]           wbs_adr_i,
  input  logic [WB_DW-1:0]     wbs_dat_i,
  input  logic [WB_DW/8-1:0]   wbs_sel_i,
  input  logic                 wbs_we_i,
  input  logic                 wbs_cyc_i,
  input  logic                 wbs_stb_i,
  output logic [WB_DW-1:0]     wbs_dat_o,
  output logic                 wbs_ack_o,
  output logic                 wbs_err_o,
  output logic                 wbs_rty_o,
  output logic                 irq_o
);
  localparam int DEPTH = 2**FIFO_AW;
  localparam int BW    = FIFO_AW + 1;
  localparam logic [BW-1:0]      MAXB  = BW'(MAX_BURST_LEN);
  localparam logic [WB_AW-1:0]   STEP  = WB_AW'(WB_DW/8);
  localparam logic [WB_DW-1:0]   DONE1 = WB_DW'(1);
  localparam logic [FIFO_AW-1:0] PONE  = FIFO_AW'(1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST, S_PEND} state_t;

  state_t             r_state;
  logic               r_enable, r_ring, r_irq_en, r_done, r_bus_err, r_irq;
  logic [WB_AW-1:0]   r_start, r_adr;
  logic [WB_DW-1:0]   r_buf_size, r_burst_size, r_tx_cnt, r_rem, r_wbs_dat;
  logic [BW-1:0]      r_burst, r_beat, r_cnt;
  logic               r_wbs_ack, r_cyc;
  logic [2:0]         r_cti;
  logic [FIFO_AW-1:0] r_wp, r_rp;
  logic [WB_DW:0]     r_mem [DEPTH];

  logic               w_acc, w_we, w_busy, w_push, w_pop, w_valid;
  logic [2:0]         w_idx;
  logic [BW-1:0]      w_bclamp, w_blen, w_free;
  logic [WB_DW-1:0]   w_rdata;
  logic [WB_DW:0]     w_head;

  assign w_acc   = wbs_cyc_i & wbs_stb_i & ~r_wbs_ack;
  assign w_we    = w_acc & wbs_we_i;
  assign w_idx   = wbs_adr_i[4:2];
  assign w_busy  = (r_state != S_IDLE);
  assign w_valid = (r_cnt != '0);
  assign w_push  = (r_state == S_BURST) & wbm_ack_i;
  assign w_pop   = w_valid & stream_m_ready_i;
  assign w_free  = BW'(DEPTH) - r_cnt;
  assign w_blen  = (r_rem < WB_DW'(r_burst)) ? r_rem[BW-1:0] : r_burst;
  assign w_head  = r_mem[r_rp];

  assign wbm_adr_o        = r_adr;
  assign wbm_dat_o        = '0;
  assign wbm_sel_o        = '1;
  assign wbm_we_o         = 1'b0;
  assign wbm_cyc_o        = r_cyc;
  assign wbm_stb_o        = r_cyc;
  assign wbm_cti_o        = r_cti;
  assign wbm_bte_o        = 2'b00;
  assign stream_m_valid_o = w_valid;
  assign stream_m_data_o  = w_valid ? w_head[WB_DW-1:0] : '0;
  assign stream_m_last_o  = w_valid & w_head[WB_DW];
  assign wbs_dat_o        = r_wbs_dat;
  assign wbs_ack_o        = r_wbs_ack;
  assign wbs_err_o        = 1'b0;
  assign wbs_rty_o        = 1'b0;
  assign irq_o            = r_irq;

  always_comb begin
    w_bclamp = MAXB;
    if (r_burst_size == '0)                       w_bclamp = BW'(1);
    else if (r_burst_size <= WB_DW'(MAX_BURST_LEN)) w_bclamp = r_burst_size[BW-1:0];
  end

  always_comb begin
    w_rdata = '0;
    case (w_idx)
      3'd0:    w_rdata = WB_DW'({r_irq_en, r_ring, w_busy});
      3'd1:    w_rdata = WB_DW'({r_bus_err, r_done});
      3'd2:    w_rdata = WB_DW'(r_start);
      3'd3:    w_rdata = r_buf_size;
      3'd4:    w_rdata = r_burst_size;
      3'd5:    w_rdata = r_tx_cnt;
      default: w_rdata = '0;
    endcase
  end

  // FIFO storage is not reset; the head is masked by valid so outputs still read 0 after reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= {(r_rem == DONE1), wbm_dat_i};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + PONE;
      if (w_pop)  r_rp <= r_rp + PONE;
      r_cnt <= r_cnt + BW'(w_push) - BW'(w_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_enable <= 1'b0; r_ring <= 1'b0; r_irq_en <= 1'b0;
      r_done <= 1'b0; r_bus_err <= 1'b0; r_irq <= 1'b0;
      r_start <= '0; r_adr <= '0;
      r_buf_size <= '0; r_burst_size <= '0; r_tx_cnt <= '0; r_rem <= '0;
      r_burst <= '0; r_beat <= '0;
      r_wbs_ack <= 1'b0; r_wbs_dat <= '0;
      r_cyc <= 1'b0; r_cti <= 3'b000;
    end else begin
      r_irq     <= r_irq_en & (r_done | r_bus_err);
      r_wbs_ack <= w_acc;
      if (w_acc) r_wbs_dat <= w_rdata;
      if (w_we) begin
        case (w_idx)
          3'd0: begin
            r_enable <= wbs_dat_i[0];
            r_ring   <= wbs_dat_i[1];
            r_irq_en <= wbs_dat_i[2];
          end
          3'd1: begin
            r_done    <= r_done    & ~wbs_dat_i[0];
            r_bus_err <= r_bus_err & ~wbs_dat_i[1];
          end
          3'd2: r_start      <= WB_AW'(wbs_dat_i);
          3'd3: r_buf_size   <= wbs_dat_i;
          3'd4: r_burst_size <= wbs_dat_i;
          default: ;
        endcase
      end
      // Engine updates come last so a status event wins over a same-cycle software write.
      case (r_state)
        S_IDLE: if (r_enable) begin
          if (r_buf_size == '0) begin
            r_done   <= 1'b1;
            r_enable <= 1'b0;
          end else begin
            r_adr    <= r_start;
            r_rem    <= r_buf_size;
            r_burst  <= w_bclamp;
            r_tx_cnt <= '0;
            r_state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!r_enable) r_state <= S_IDLE;
          else if (w_free >= w_blen) begin
            r_state <= S_BURST;
            r_cyc   <= 1'b1;
            r_beat  <= w_blen;
            r_cti   <= (w_blen == BW'(1)) ? 3'b111 : 3'b010;
          end
        end
        S_BURST: begin
          if (wbm_ack_i) begin
            r_adr    <= r_adr + STEP;
            r_rem    <= r_rem - DONE1;
            r_tx_cnt <= r_tx_cnt + DONE1;
            r_beat   <= r_beat - BW'(1);
            r_cti    <= (r_beat == BW'(2)) ? 3'b111 : 3'b010;
            if (r_beat == BW'(1)) begin
              r_cyc   <= 1'b0;
              r_state <= (r_rem == DONE1) ? S_PEND : S_WAIT;
            end
          end else if (wbm_err_i) begin
            r_cyc     <= 1'b0;
            r_bus_err <= 1'b1;
            r_enable  <= 1'b0;
            r_state   <= S_IDLE;
          end else if (wbm_rty_i) begin
            r_cyc   <= 1'b0;
            r_state <= S_WAIT;
          end
        end
        S_PEND: begin
          r_done <= 1'b1;
          if (r_ring && r_enable && r_buf_size != '0) begin
            r_adr    <= r_start;
            r_rem    <= r_buf_size;
            r_burst  <= w_bclamp;
            r_tx_cnt <= '0;
            r_state  <= S_WAIT;
          end else begin
            r_enable <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_stream_writer_ring.sv
// Directed bench: memory slave model returns {~adr[15:0], adr[15:0]}, with err/rty injected
// on a chosen beat; stream and bus traffic are logged and compared to hand-derived values.
module tb_wb_stream_writer_ring;
  localparam int DW = 32, AW = 32, FAW = 2;

  logic clk = 1'b0, rst = 1'b1;
  logic [AW-1:0] wbm_adr_o;
  logic [DW-1:0] wbm_dat_o, wbm_dat_i;
  logic [3:0]    wbm_sel_o;
  logic          wbm_we_o, wbm_cyc_o, wbm_stb_o, wbm_ack_i, wbm_err_i, wbm_rty_i;
  logic [2:0]    wbm_cti_o;
  logic [1:0]    wbm_bte_o;
  logic [DW-1:0] stream_m_data_o;
  logic          stream_m_valid_o, stream_m_last_o;
  logic          stream_m_ready_i = 1'b1;
  logic [4:0]    wbs_adr_i = '0;
  logic [DW-1:0] wbs_dat_i = '0, wbs_dat_o;
  logic [3:0]    wbs_sel_i = 4'hf;
  logic          wbs_we_i = 1'b0, wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0;
  logic          wbs_ack_o, wbs_err_o, wbs_rty_o, irq_o;

  wb_stream_writer_ring #(.WB_DW(DW), .WB_AW(AW), .FIFO_AW(FAW), .MAX_BURST_LEN(4)) dut (
    .clk(clk), .rst(rst),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o), .wbm_we_o(wbm_we_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .wbm_rty_i(wbm_rty_i),
    .stream_m_data_o(stream_m_data_o), .stream_m_valid_o(stream_m_valid_o),
    .stream_m_ready_i(stream_m_ready_i), .stream_m_last_o(stream_m_last_o),
    .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_sel_i(wbs_sel_i), .wbs_we_i(wbs_we_i),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o),
    .wbs_err_o(wbs_err_o), .wbs_rty_o(wbs_rty_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  int beat_in_cyc = 0, err_beat = 0, rty_beat = 0;
  logic w_hit;
  assign w_hit     = wbm_cyc_o & wbm_stb_o;
  assign wbm_err_i = w_hit && (err_beat == beat_in_cyc + 1);
  assign wbm_rty_i = w_hit && (rty_beat == beat_in_cyc + 1);
  assign wbm_ack_i = w_hit & ~wbm_err_i & ~wbm_rty_i;
  assign wbm_dat_i = {~wbm_adr_o[15:0], wbm_adr_o[15:0]};

  function automatic logic [31:0] exp_dat(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  logic [31:0] ack_adr[$], st_dat[$];
  logic [2:0]  ack_cti[$];
  logic        st_last[$];
  int occ = 0, max_occ = 0, vmis = 0, cyc_starts = 0, err_drop_bad = 0;
  logic prev_cyc = 1'b0, prev_err = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      occ = 0; prev_cyc = 1'b0; prev_err = 1'b0;
      beat_in_cyc <= 0;
    end else begin
      if (stream_m_valid_o !== (occ != 0)) vmis++;
      if (wbm_ack_i) begin ack_adr.push_back(wbm_adr_o); ack_cti.push_back(wbm_cti_o); end
      if (stream_m_valid_o && stream_m_ready_i) begin
        st_dat.push_back(stream_m_data_o); st_last.push_back(stream_m_last_o);
      end
      if (prev_err && wbm_cyc_o) err_drop_bad++;
      if (wbm_cyc_o && !prev_cyc) cyc_starts++;
      prev_err = wbm_err_i;
      prev_cyc = wbm_cyc_o;
      occ = occ + int'(wbm_ack_i) - int'(stream_m_valid_o && stream_m_ready_i);
      if (occ > max_occ) max_occ = occ;
      beat_in_cyc <= wbm_cyc_o ? beat_in_cyc + int'(wbm_ack_i) : 0;
    end
  end

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic wb_xfer(input int idx, input logic we, input logic [31:0] d, output logic [31:0] q);
    bit ok = 0;
    @(negedge clk);
    wbs_adr_i = 5'(idx * 4); wbs_dat_i = d; wbs_we_i = we; wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    q = '0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(posedge clk); #1;
      if (wbs_ack_o) begin ok = 1; q = wbs_dat_o; end
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    if (!ok) chk("slave ack timeout", 32'd0, 32'd1);
  endtask

  task automatic wb_wr(input int idx, input logic [31:0] d);
    logic [31:0] q;
    wb_xfer(idx, 1'b1, d, q);
  endtask

  task automatic rd_chk(input string tag, input int idx, input logic [31:0] exp);
    logic [31:0] q;
    wb_xfer(idx, 1'b0, '0, q);
    chk(tag, q, exp);
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] q = 32'd1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 300 && q[0]; k++) wb_xfer(0, 1'b0, '0, q);
    chk({tag, " idle"}, 32'(q[0]), 32'd0);
  endtask

  task automatic wait_words(input string tag, input int n);
    for (int k = 0; k < 1000 && st_dat.size() < n; k++) @(negedge clk);
    chk({tag, " words"}, 32'(st_dat.size() >= n), 32'd1);
  endtask

  task automatic start(input logic [31:0] sa, input logic [31:0] bs, input logic [31:0] bu,
                       input logic [31:0] ctrl);
    wb_wr(2, sa); wb_wr(3, bs); wb_wr(4, bu); wb_wr(0, ctrl);
  endtask

  logic [2:0] cti1[10] = '{3'd2, 3'd2, 3'd2, 3'd7, 3'd2, 3'd2, 3'd2, 3'd7, 3'd2, 3'd7};
  logic [2:0] cti9[5]  = '{3'd2, 3'd2, 3'd2, 3'd7, 3'd7};

  initial begin
    int a0, s0, c0, bad, n;
    repeat (3) @(negedge clk);
    chk("rst cyc", 32'(wbm_cyc_o), 32'd0);
    chk("rst valid", 32'(stream_m_valid_o), 32'd0);
    chk("rst irq", 32'(irq_o), 32'd0);
    chk("rst adr", wbm_adr_o, 32'd0);
    chk("rst sel", 32'(wbm_sel_o), 32'hf);
    rst = 1'b0;
    rd_chk("rst ctrl", 0, 32'd0);
    rd_chk("rst status", 1, 32'd0);
    rd_chk("rst txcnt", 5, 32'd0);
    rd_chk("unmapped", 7, 32'd0);

    // one-shot, 10 words in bursts of 4,4,2
    a0 = ack_adr.size(); s0 = st_dat.size(); c0 = cyc_starts;
    start(32'h1000, 32'd10, 32'd4, 32'h1);
    wait_words("oneshot", s0 + 10);
    wait_idle("oneshot");
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("oneshot adr%0d", i), ack_adr[a0+i], 32'h1000 + 32'(4 * i));
      chk($sformatf("oneshot cti%0d", i), 32'(ack_cti[a0+i]), 32'(cti1[i]));
      chk($sformatf("oneshot dat%0d", i), st_dat[s0+i], exp_dat(32'h1000 + 32'(4 * i)));
      chk($sformatf("oneshot last%0d", i), 32'(st_last[s0+i]), 32'(i == 9));
    end
    chk("oneshot bursts", 32'(cyc_starts - c0), 32'd3);
    rd_chk("oneshot status", 1, 32'd1);
    rd_chk("oneshot txcnt", 5, 32'd10);
    rd_chk("oneshot ctrl", 0, 32'd0);
    wb_wr(1, 32'h1);
    rd_chk("status w1c", 1, 32'd0);

    // backpressure: ready high one cycle in four
    s0 = st_dat.size(); c0 = cyc_starts; max_occ = 0;
    start(32'h2000, 32'd16, 32'd4, 32'h1);
    for (int k = 0; k < 3000 && st_dat.size() < s0 + 16; k++) begin
      @(negedge clk); stream_m_ready_i = (k % 4 == 0);
    end
    stream_m_ready_i = 1'b1;
    chk("bp words", 32'(st_dat.size() - s0), 32'd16);
    wait_idle("bp");
    bad = 0;
    for (int i = 0; i < 16; i++)
      if (st_dat[s0+i] !== exp_dat(32'h2000 + 32'(4 * i)) || st_last[s0+i] !== (i == 15)) bad++;
    chk("bp order", 32'(bad), 32'd0);
    chk("bp max occ", 32'(max_occ <= 4), 32'd1);
    chk("bp bursts", 32'(cyc_starts - c0), 32'd4);
    wb_wr(1, 32'h3);

    // ring: 3 words per pass, then stop
    a0 = ack_adr.size(); s0 = st_dat.size();
    start(32'h1000, 32'd3, 32'd2, 32'h3);
    wait_words("ring", s0 + 9);
    wb_wr(0, 32'h0);
    wait_idle("ring");
    c0 = cyc_starts;
    repeat (20) @(negedge clk);
    chk("ring no cyc after stop", 32'(cyc_starts), 32'(c0));
    n = ack_adr.size() - a0;
    chk("ring stream count", 32'(st_dat.size() - s0), 32'(n));
    chk("ring stop boundary", 32'(n % 3 != 1), 32'd1);
    bad = 0;
    for (int i = 0; i < n; i++) begin
      if (ack_adr[a0+i] !== 32'h1000 + 32'(4 * (i % 3))) bad++;
      if (st_dat[s0+i] !== exp_dat(32'h1000 + 32'(4 * (i % 3)))) bad++;
      if (st_last[s0+i] !== (i % 3 == 2)) bad++;
    end
    chk("ring pattern", 32'(bad), 32'd0);
    rd_chk("ring done", 1, 32'd1);
    wb_wr(1, 32'h3);

    // bus error on beat 2 of the first burst
    a0 = ack_adr.size(); s0 = st_dat.size(); err_beat = 2;
    start(32'h3000, 32'd8, 32'd4, 32'h5);
    wait_idle("err");
    repeat (3) @(negedge clk);
    err_beat = 0;
    chk("err acks", 32'(ack_adr.size() - a0), 32'd1);
    chk("err drained", 32'(st_dat.size() - s0), 32'd1);
    chk("err dat", st_dat[s0], exp_dat(32'h3000));
    chk("err cyc drop", 32'(err_drop_bad), 32'd0);
    rd_chk("err status", 1, 32'd2);
    rd_chk("err ctrl", 0, 32'd4);
    chk("err irq", 32'(irq_o), 32'd1);
    wb_wr(1, 32'h2);
    repeat (3) @(negedge clk);
    chk("err irq cleared", 32'(irq_o), 32'd0);
    wb_wr(0, 32'h0);

    // retry on beat 3: restart at 0x1008 with 2 beats
    a0 = ack_adr.size(); s0 = st_dat.size(); c0 = cyc_starts; rty_beat = 3;
    start(32'h1000, 32'd4, 32'd4, 32'h1);
    wait_words("rty", s0 + 4);
    wait_idle("rty");
    rty_beat = 0;
    chk("rty acks", 32'(ack_adr.size() - a0), 32'd4);
    chk("rty adr2", ack_adr[a0+2], 32'h1008);
    chk("rty adr3", ack_adr[a0+3], 32'h100c);
    chk("rty cti2", 32'(ack_cti[a0+2]), 32'd2);
    chk("rty cti3", 32'(ack_cti[a0+3]), 32'd7);
    chk("rty bursts", 32'(cyc_starts - c0), 32'd2);
    chk("rty words", 32'(st_dat.size() - s0), 32'd4);
    chk("rty dat3", st_dat[s0+3], exp_dat(32'h100c));
    chk("rty last", 32'(st_last[s0+3]), 32'd1);
    rd_chk("rty txcnt", 5, 32'd4);
    wb_wr(1, 32'h3);

    // BUF=0: immediate done, no bus cycle
    c0 = cyc_starts;
    start(32'h1000, 32'd0, 32'd4, 32'h1);
    repeat (5) @(negedge clk);
    rd_chk("buf0 status", 1, 32'd1);
    rd_chk("buf0 ctrl", 0, 32'd0);
    chk("buf0 no cyc", 32'(cyc_starts), 32'(c0));
    wb_wr(1, 32'h3);

    // BURST=0 acts as single-beat bursts
    a0 = ack_adr.size(); c0 = cyc_starts;
    start(32'h4000, 32'd2, 32'd0, 32'h1);
    wait_idle("burst0");
    chk("burst0 cti0", 32'(ack_cti[a0]), 32'd7);
    chk("burst0 cti1", 32'(ack_cti[a0+1]), 32'd7);
    chk("burst0 bursts", 32'(cyc_starts - c0), 32'd2);

    // BURST=9 clamps to 4
    a0 = ack_adr.size(); c0 = cyc_starts;
    start(32'h5000, 32'd5, 32'd9, 32'h1);
    wait_idle("clamp");
    for (int i = 0; i < 5; i++)
      chk($sformatf("clamp cti%0d", i), 32'(ack_cti[a0+i]), 32'(cti9[i]));
    chk("clamp bursts", 32'(cyc_starts - c0), 32'd2);
    wb_wr(1, 32'h3);

    // asynchronous reset in the middle of a burst
    stream_m_ready_i = 1'b0;
    start(32'h6000, 32'd8, 32'd4, 32'h1);
    for (int k = 0; k < 100 && beat_in_cyc < 2; k++) @(negedge clk);
    chk("arst mid burst", 32'(wbm_cyc_o & stream_m_valid_o), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst cyc", 32'(wbm_cyc_o), 32'd0);
    chk("arst stb", 32'(wbm_stb_o), 32'd0);
    chk("arst valid", 32'(stream_m_valid_o), 32'd0);
    @(negedge clk); rst = 1'b0; stream_m_ready_i = 1'b1;
    rd_chk("arst ctrl", 0, 32'd0);
    rd_chk("arst txcnt", 5, 32'd0);

    chk("valid vs occupancy", 32'(vmis), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
